// File: rtl/tape_buff_arb.sv
// Single-port buffer arbiter: one download writer (via a one-entry holding
// register) and two round-robin readers, one memory transaction at a time.
module tape_buff_arb #(
    parameter int ADDR_W  = 25,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_sys,
    input  logic              reset,

    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [ADDR_W-1:0] ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,

    input  logic              tape_rd,
    input  logic [ADDR_W-1:0] tape_addr,
    output logic              tape_rd_en,
    output logic [7:0]        tape_din,

    input  logic              snap_rd,
    input  logic [ADDR_W-1:0] snap_addr,
    output logic              snap_ack,
    output logic [7:0]        snap_din,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,

    output logic [ADDR_W-1:0] tape_size,
    output logic              err
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WR, RD_TAPE, RD_SNAP} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              hold_full_q, hold_full_d;
    logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
    logic [7:0]        hold_data_q, hold_data_d;
    logic              prio_snap_q, prio_snap_d;
    logic              dl_q, dl_d;
    logic [ADDR_W-1:0] max_q, max_d;
    logic [ADDR_W-1:0] tape_size_q, tape_size_d;
    logic              err_q, err_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              tape_rd_en_q, tape_rd_en_d;
    logic [7:0]        tape_din_q, tape_din_d;
    logic              snap_ack_q, snap_ack_d;
    logic [7:0]        snap_din_q, snap_din_d;

    logic              dl_rise, dl_fall;
    logic              tape_win, snap_win;
    logic              expired;
    logic [7:0]        rdata;
    logic [ADDR_W-1:0] wr_end;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            hold_full_q  <= 1'b0;
            hold_addr_q  <= '0;
            hold_data_q  <= '0;
            prio_snap_q  <= 1'b0;
            dl_q         <= 1'b0;
            max_q        <= '0;
            tape_size_q  <= '0;
            err_q        <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            tape_rd_en_q <= 1'b0;
            tape_din_q   <= '0;
            snap_ack_q   <= 1'b0;
            snap_din_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hold_full_q  <= hold_full_d;
            hold_addr_q  <= hold_addr_d;
            hold_data_q  <= hold_data_d;
            prio_snap_q  <= prio_snap_d;
            dl_q         <= dl_d;
            max_q        <= max_d;
            tape_size_q  <= tape_size_d;
            err_q        <= err_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            tape_rd_en_q <= tape_rd_en_d;
            tape_din_q   <= tape_din_d;
            snap_ack_q   <= snap_ack_d;
            snap_din_q   <= snap_din_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hold_full_d  = hold_full_q;
        hold_addr_d  = hold_addr_q;
        hold_data_d  = hold_data_q;
        prio_snap_d  = prio_snap_q;
        dl_d         = ioctl_download;
        max_d        = max_q;
        tape_size_d  = tape_size_q;
        err_d        = err_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        tape_rd_en_d = 1'b0;
        tape_din_d   = tape_din_q;
        snap_ack_d   = 1'b0;
        snap_din_d   = snap_din_q;

        dl_rise  = ioctl_download & ~dl_q;
        dl_fall  = ~ioctl_download & dl_q;
        wr_end   = ioctl_addr + ADDR_W'(1);
        tape_win = 1'b0;
        snap_win = 1'b0;
        expired  = 1'b0;
        rdata    = mem_ack ? mem_rdata : 8'hFF;

        // Clears come first so a fault or write in the same cycle still lands.
        if (dl_rise) begin
            max_d = '0;
            err_d = 1'b0;
        end
        if (dl_fall) begin
            tape_size_d = max_q;
        end

        if (ioctl_wr) begin
            if (hold_full_q) begin
                err_d = 1'b1;
            end else begin
                hold_full_d = 1'b1;
                hold_addr_d = ioctl_addr;
                hold_data_d = ioctl_dout;
                if (ioctl_download && (wr_end > max_d)) begin
                    max_d = wr_end;
                end
            end
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (hold_full_q) begin
                    state_d     = WR;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = hold_addr_q;
                    mem_wdata_d = hold_data_q;
                end else if (!ioctl_download) begin
                    tape_win = tape_rd & (~snap_rd | ~prio_snap_q);
                    snap_win = snap_rd & ~tape_win;
                    if (tape_win) begin
                        state_d     = RD_TAPE;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = tape_addr;
                        prio_snap_d = 1'b1;
                    end else if (snap_win) begin
                        state_d     = RD_SNAP;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = snap_addr;
                        prio_snap_d = 1'b0;
                    end
                end
            end
            default: begin
                expired = ~mem_ack & (cnt_q == CNT_W'(TIMEOUT - 1));
                if (mem_ack || expired) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (expired) begin
                        err_d = 1'b1;
                    end
                    case (state_q)
                        WR:      hold_full_d = 1'b0;
                        RD_TAPE: begin
                            tape_rd_en_d = 1'b1;
                            tape_din_d   = rdata;
                        end
                        default: begin
                            snap_ack_d = 1'b1;
                            snap_din_d = rdata;
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    assign ioctl_wait = hold_full_q;
    assign tape_rd_en = tape_rd_en_q;
    assign tape_din   = tape_din_q;
    assign snap_ack   = snap_ack_q;
    assign snap_din   = snap_din_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign tape_size  = tape_size_q;
    assign err        = err_q;

endmodule

// File: tb/tb_tape_buff_arb.sv
// Scoreboard bench for tape_buff_arb: a responder plays the memory, the
// stimulus queues expected transactions/reads, and a monitor pops and checks.
module tb_tape_buff_arb;

    localparam int AW = 25;
    localparam int TO = 8;

    logic          clk_sys = 1'b0;
    logic          reset = 1'b1;
    logic          ioctl_download = 1'b0, ioctl_wr = 1'b0, ioctl_wait;
    logic [AW-1:0] ioctl_addr = '0;
    logic [7:0]    ioctl_dout = '0;
    logic          tape_rd = 1'b0, tape_rd_en;
    logic [AW-1:0] tape_addr = '0;
    logic [7:0]    tape_din;
    logic          snap_rd = 1'b0, snap_ack;
    logic [AW-1:0] snap_addr = '0;
    logic [7:0]    snap_din;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata = '0;
    logic          mem_ack = 1'b0;
    logic [AW-1:0] tape_size;
    logic          err;

    tape_buff_arb #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
        .tape_rd(tape_rd), .tape_addr(tape_addr), .tape_rd_en(tape_rd_en), .tape_din(tape_din),
        .snap_rd(snap_rd), .snap_addr(snap_addr), .snap_ack(snap_ack), .snap_din(snap_din),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .tape_size(tape_size), .err(err)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } txn_t;
    typedef struct {
        logic       is_snap;
        logic [7:0] data;
    } rd_t;

    txn_t exp_txn[$];
    rd_t  exp_rd[$];
    int   checks = 0;
    int   errors = 0;
    int   ack_lat = 1;
    int   wcnt = 0;
    int   req_len = 0;
    int   last_req_len = 0;
    logic prev_req = 1'b0, prev_tv = 1'b0, prev_sv = 1'b0;
    logic [AW-1:0] held_addr = '0;

    function automatic logic [7:0] rd_model(input logic [AW-1:0] a);
        return a[7:0] ^ 8'hC3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event present, none expected", name);
    endtask

    // Memory responder: ack ack_lat cycles into a request; 0 means never.
    always @(negedge clk_sys) begin
        mem_ack = 1'b0;
        if (mem_req && !reset) begin
            wcnt++;
            if (ack_lat != 0 && wcnt == ack_lat) begin
                mem_ack   = 1'b1;
                mem_rdata = rd_model(mem_addr);
                wcnt      = 0;
            end
        end else begin
            wcnt = 0;
        end
    end

    task automatic on_valid(input logic is_snap, input logic [7:0] d, input logic prev);
        rd_t r;
        check(is_snap ? "snap_pulse_width" : "tape_pulse_width", {31'd0, prev}, 32'd0);
        if (exp_rd.size() == 0) begin
            fail_now(is_snap ? "snap_ack_unexpected" : "tape_rd_en_unexpected");
        end else begin
            r = exp_rd.pop_front();
            check("valid_source", {31'd0, is_snap}, {31'd0, r.is_snap});
            check("valid_data", {24'd0, d}, {24'd0, r.data});
        end
    endtask

    always @(negedge clk_sys) begin
        txn_t t;
        if (mem_req && !prev_req) begin
            if (exp_txn.size() == 0) begin
                fail_now("mem_req_unexpected");
            end else begin
                t = exp_txn.pop_front();
                check("txn_we", {31'd0, mem_we}, {31'd0, t.we});
                check("txn_addr", 32'(mem_addr), 32'(t.addr));
                if (t.we) check("txn_wdata", {24'd0, mem_wdata}, {24'd0, t.data});
            end
            held_addr = mem_addr;
            req_len   = 1;
        end else if (mem_req) begin
            req_len++;
            if (mem_addr !== held_addr) check("txn_addr_stable", 32'(mem_addr), 32'(held_addr));
        end
        if (!mem_req && prev_req) last_req_len = req_len;
        if (tape_rd_en) on_valid(1'b0, tape_din, prev_tv);
        if (snap_ack) on_valid(1'b1, snap_din, prev_sv);
        prev_req = mem_req;
        prev_tv  = tape_rd_en;
        prev_sv  = snap_ack;
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
        check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, {24'd0, mem_wdata}, 32'd0);
        check({tag, "_tape_rd_en"}, {31'd0, tape_rd_en}, 32'd0);
        check({tag, "_snap_ack"}, {31'd0, snap_ack}, 32'd0);
        check({tag, "_tape_din"}, {24'd0, tape_din}, 32'd0);
        check({tag, "_snap_din"}, {24'd0, snap_din}, 32'd0);
        check({tag, "_ioctl_wait"}, {31'd0, ioctl_wait}, 32'd0);
        check({tag, "_tape_size"}, 32'(tape_size), 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    task automatic wait_wait_low();
        int n = 0;
        while (ioctl_wait && n < 60) begin
            @(negedge clk_sys);
            n++;
        end
        if (ioctl_wait) fail_now("ioctl_wait_stuck");
    endtask

    task automatic wait_valids(input int count);
        int seen = 0;
        int n = 0;
        while (seen < count && n < 200) begin
            @(negedge clk_sys);
            n++;
            if (tape_rd_en || snap_ack) seen++;
        end
        if (seen < count) fail_now("valid_timeout");
    endtask

    task automatic write_pulse(input logic [AW-1:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        @(negedge clk_sys);
        ioctl_wr   = 1'b0;
    endtask

    initial begin
        logic [7:0] dl_data [3];
        int n;
        dl_data = '{8'h11, 8'h22, 8'h33};

        repeat (2) @(negedge clk_sys);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk_sys);

        // Download of three bytes, ack latency 2.
        ack_lat = 2;
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        for (int i = 0; i < 3; i++) begin
            exp_txn.push_back('{1'b1, AW'(i), dl_data[i]});
            write_pulse(AW'(i), dl_data[i]);
            wait_wait_low();
        end
        ioctl_download = 1'b0;
        repeat (2) @(negedge clk_sys);
        check("dl_tape_size", 32'(tape_size), 32'd3);
        check("dl_err", {31'd0, err}, 32'd0);

        // Both readers held: alternate tape, snap, tape, snap.
        ack_lat = 1;
        tape_addr = AW'(32'h10);
        snap_addr = AW'(32'h20);
        for (int i = 0; i < 2; i++) begin
            exp_txn.push_back('{1'b0, AW'(32'h10), 8'h00});
            exp_txn.push_back('{1'b0, AW'(32'h20), 8'h00});
            exp_rd.push_back('{1'b0, rd_model(AW'(32'h10))});
            exp_rd.push_back('{1'b1, rd_model(AW'(32'h20))});
        end
        tape_rd = 1'b1;
        snap_rd = 1'b1;
        wait_valids(4);
        tape_rd = 1'b0;
        snap_rd = 1'b0;
        repeat (3) @(negedge clk_sys);

        // Pending write beats a simultaneous tape read.
        ack_lat = 2;
        exp_txn.push_back('{1'b1, AW'(5), 8'h77});
        exp_txn.push_back('{1'b0, AW'(32'h30), 8'h00});
        exp_rd.push_back('{1'b0, rd_model(AW'(32'h30))});
        write_pulse(AW'(5), 8'h77);
        tape_addr = AW'(32'h30);
        tape_rd = 1'b1;
        wait_valids(1);
        tape_rd = 1'b0;
        repeat (3) @(negedge clk_sys);

        // Unanswered tape read aborts after TIMEOUT cycles with FF.
        ack_lat = 0;
        exp_txn.push_back('{1'b0, AW'(32'h40), 8'h00});
        exp_rd.push_back('{1'b0, 8'hFF});
        tape_addr = AW'(32'h40);
        tape_rd = 1'b1;
        @(negedge clk_sys);
        tape_rd = 1'b0;
        wait_valids(1);
        @(negedge clk_sys);
        check("timeout_req_len", 32'(last_req_len), 32'(TO));
        check("timeout_err", {31'd0, err}, 32'd1);

        // Overlapping write is dropped; err clears on the next download start.
        ack_lat = 4;
        ioctl_download = 1'b1;
        repeat (2) @(negedge clk_sys);
        check("dl_rise_clears_err", {31'd0, err}, 32'd0);
        exp_txn.push_back('{1'b1, AW'(7), 8'hA1});
        write_pulse(AW'(7), 8'hA1);
        check("wait_when_full", {31'd0, ioctl_wait}, 32'd1);
        write_pulse(AW'(8), 8'hB2);
        wait_wait_low();
        check("drop_sets_err", {31'd0, err}, 32'd1);
        ioctl_download = 1'b0;
        repeat (2) @(negedge clk_sys);
        check("drop_tape_size", 32'(tape_size), 32'd8);
        ioctl_download = 1'b1;
        repeat (2) @(negedge clk_sys);
        check("dl2_err_cleared", {31'd0, err}, 32'd0);
        check("dl2_size_held", 32'(tape_size), 32'd8);
        ioctl_download = 1'b0;
        repeat (2) @(negedge clk_sys);
        check("empty_dl_tape_size", 32'(tape_size), 32'd0);

        // Reset in the middle of a snapshot read wait.
        ack_lat = 0;
        exp_txn.push_back('{1'b0, AW'(32'h50), 8'h00});
        snap_addr = AW'(32'h50);
        snap_rd = 1'b1;
        n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk_sys);
            n++;
        end
        if (!mem_req) fail_now("snap_req_timeout");
        repeat (2) @(negedge clk_sys);
        #2 reset = 1'b1;
        #1 check_reset_outputs("midrst");
        snap_rd = 1'b0;
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
        repeat (12) @(negedge clk_sys);
        check("midrst_no_snap_ack", {31'd0, snap_ack}, 32'd0);
        check("txn_queue_drained", 32'(exp_txn.size()), 32'd0);
        check("rd_queue_drained", 32'(exp_rd.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/tape_buff_arb.md
TAPE_BUFF_ARB -- requirements
Module: tape_buff_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 25, buffer address width.
REQ-002 SHALL have parameter TIMEOUT, default 255, max cycles to wait for mem_ack before abort.
REQ-003 SHALL have port clk_sys  in  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports ioctl_download in 1 download active; ioctl_wr in 1 write strobe; ioctl_addr in ADDR_W write address; ioctl_dout in 8 write data; ioctl_wait out 1 writer stall.
REQ-006 SHALL have ports tape_rd in 1 tape read request (level, held until served); tape_addr in ADDR_W; tape_rd_en out 1 data-valid pulse; tape_din out 8 read data.
REQ-007 SHALL have ports snap_rd in 1 snapshot read request (level); snap_addr in ADDR_W; snap_ack out 1 data-valid pulse; snap_din out 8 read data.
REQ-008 SHALL have ports mem_req out 1; mem_we out 1; mem_addr out ADDR_W; mem_wdata out 8; mem_rdata in 8; mem_ack in 1 (one-cycle completion pulse).
REQ-009 SHALL have ports tape_size out ADDR_W bytes in last download; err out 1 sticky fault flag.

Function
REQ-010 SHALL implement FSM states IDLE, WR, RD_TAPE, RD_SNAP; one memory transaction at a time.
REQ-011 SHALL capture each ioctl_wr pulse (addr, data) into a one-entry holding register in the same edge.
REQ-012 SHALL drive ioctl_wait high combinationally while the holding register is full.
REQ-013 SHALL, if ioctl_wr arrives with holding register full, drop the new write and set err.
REQ-014 SHALL in IDLE grant in priority order: pending write, then readers round-robin (winner of last read grant has lower priority; after reset tape first).
REQ-015 SHALL not grant tape_rd or snap_rd while ioctl_download is high.
REQ-016 SHALL on grant assert mem_req, mem_addr, mem_we, mem_wdata on the next edge and hold them stable until mem_ack or timeout.
REQ-017 SHALL on mem_ack deassert mem_req, return to IDLE, free holding register (WR) or pulse the reader's valid for exactly one cycle with data registered from mem_rdata.
REQ-018 SHALL count wait cycles per transaction; at TIMEOUT cycles without mem_ack abort, drop mem_req, set err; aborted reads return 8'hFF with valid pulse; aborted writes free holding register.
REQ-019 SHALL allow back-to-back transactions: minimum one IDLE cycle between mem_ack and next mem_req.
REQ-020 SHALL ignore a reader request deasserted before grant; once granted, transaction completes regardless of request level.
REQ-021 SHALL track max(ioctl_addr)+1 of accepted writes during download; on ioctl_download falling edge latch it to tape_size.
REQ-022 SHALL clear the max tracker on ioctl_download rising edge; tape_size holds value until next falling edge.
REQ-023 SHALL, on rising edge of ioctl_download, clear err.
REQ-024 SHALL, if mem_ack arrives in IDLE (spurious), ignore it.

Reset
REQ-025 SHALL on reset force: state IDLE, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, tape_rd_en 0, snap_ack 0, tape_din 0, snap_din 0, holding register empty, ioctl_wait 0, tape_size 0, err 0, round-robin pointer to tape.
REQ-026 SHALL on reset asserted mid-transaction abandon it immediately without valid pulse.

Verification
REQ-027 Download 3 writes (addr 0,1,2; data 11,22,33), mem_ack 2 cycles after each req -> three mem_we transactions in order, download fall -> tape_size=3, err=0.
REQ-028 tape_rd and snap_rd both held continuously, ack latency 1 -> grants alternate tape, snap, tape, snap; each valid pulse exactly one cycle with mem_rdata value.
REQ-029 Write pending plus tape_rd simultaneously with ioctl_download=0 -> write issued first, then tape read.
REQ-030 Never ack a tape read with TIMEOUT=8 -> mem_req drops after 8 cycles, tape_rd_en pulses with tape_din=FF, err=1.
REQ-031 Second ioctl_wr while first unacked -> ioctl_wait=1, second write dropped, err=1; next download start -> err=0.
REQ-032 Assert reset during RD_SNAP wait -> mem_req=0 asynchronously, no snap_ack, all outputs at reset values.
